alu_ctrl_seq: RTL and testbench

//  Registered, handshaked ALU control for the pipelined core. Decodes aluop/funct3/funct7

---
 rtl/alu_ctrl_seq_pkg.sv | 63 ++++++
 rtl/alu_ctrl_seq_if.sv | 37 +++
 rtl/alu_ctrl_seq_dec.sv | 90 +++++++++
 rtl/alu_ctrl_seq.sv | 102 ++++++++++
 tb/tb_alu_ctrl_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq_pkg
// Shared constants for the ID->EX ALU control slice:
//   OP_*      5-bit ALU operation encodings (bit 4 set = M-extension op)
//   ALUOP_*   2-bit coarse op class from the main decoder
//   FUNCT7_*  funct7 patterns that select base / alternate / mul-div ops
// Helpers:
//   base_op() maps funct3 to the base integer op (funct7 = 0000000 meaning)
//   is_div()  tells DIV*/REM* apart from MUL* within the M-extension group
// -----------------------------------------------------------------------------
package alu_ctrl_seq_pkg;

   localparam logic [4:0] OP_AND    = 5'b00000;
   localparam logic [4:0] OP_OR     = 5'b00001;
   localparam logic [4:0] OP_ADD    = 5'b00010;
   localparam logic [4:0] OP_XOR    = 5'b00011;
   localparam logic [4:0] OP_SLL    = 5'b00100;
   localparam logic [4:0] OP_SRL    = 5'b00101;
   localparam logic [4:0] OP_SUB    = 5'b00110;
   localparam logic [4:0] OP_SRA    = 5'b00111;
   localparam logic [4:0] OP_SLT    = 5'b01000;
   localparam logic [4:0] OP_SLTU   = 5'b01001;
   localparam logic [4:0] OP_PASSB  = 5'b01010;
   localparam logic [4:0] OP_MUL    = 5'b10000;
   localparam logic [4:0] OP_MULH   = 5'b10001;
   localparam logic [4:0] OP_MULHSU = 5'b10010;
   localparam logic [4:0] OP_MULHU  = 5'b10011;
   localparam logic [4:0] OP_DIV    = 5'b10100;
   localparam logic [4:0] OP_DIVU   = 5'b10101;
   localparam logic [4:0] OP_REM    = 5'b10110;
   localparam logic [4:0] OP_REMU   = 5'b10111;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_ARITH  = 2'b10;
   localparam logic [1:0] ALUOP_LUI    = 2'b11;

   localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // Base integer op selected by funct3 when funct7 carries no modifier.
   function automatic logic [4:0] base_op(input logic [2:0] f3);
      logic [4:0] op;
      case (f3)
         3'b000:  op = OP_ADD;
         3'b001:  op = OP_SLL;
         3'b010:  op = OP_SLT;
         3'b011:  op = OP_SLTU;
         3'b100:  op = OP_XOR;
         3'b101:  op = OP_SRL;
         3'b110:  op = OP_OR;
         default: op = OP_AND;
      endcase
      return op;
   endfunction

   // Within the M group, funct3[2] (op bit 2) separates DIV/REM from MUL.
   function automatic logic is_div(input logic [4:0] op);
      return op[4] && op[2];
   endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq_if
// Request/response bundle between ID (master) and the ALU control stage (slave).
//   flush                       squash held op and EX occupancy
//   in_valid/in_ready           request handshake
//   aluop/funct3/funct7/is_imm  instruction fields to decode
//   out_valid/out_ready         decoded-op handshake toward EX
//   operation/multicycle/illegal decoded result
//   busy                        EX occupied by a multi-cycle op
// -----------------------------------------------------------------------------
interface alu_ctrl_seq_if #(
   parameter int OP_W = 5
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      aluop;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            is_imm;
   logic            out_valid;
   logic            out_ready;
   logic [OP_W-1:0] operation;
   logic            multicycle;
   logic            illegal;
   logic            busy;

   modport master (
      output flush, in_valid, aluop, funct3, funct7, is_imm, out_ready,
      input  in_ready, out_valid, operation, multicycle, illegal, busy
   );

   modport slave (
      input  flush, in_valid, aluop, funct3, funct7, is_imm, out_ready,
      output in_ready, out_valid, operation, multicycle, illegal, busy
   );
endinterface

// File: rtl/alu_ctrl_seq_dec.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq_dec
// Pure combinational decode of aluop/funct3/funct7/is_imm into an ALU op code.
// Ports:
//   aluop, funct3, funct7, is_imm  in   instruction fields
//   operation                      out  OP_W-bit op code (zero-extended)
//   multicycle                     out  op is an M-extension op
//   illegal                        out  encoding not recognised; op forced to ADD
// -----------------------------------------------------------------------------
module alu_ctrl_seq_dec
   import alu_ctrl_seq_pkg::*;
#(
   parameter int OP_W = 5,
   parameter bit EN_M = 1'b1
) (
   input  logic [1:0]      aluop,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic            is_imm,
   output logic [OP_W-1:0] operation,
   output logic            multicycle,
   output logic            illegal
);

   logic [4:0] op5;
   logic       mc;
   logic       ill;
   logic       shift_f3;

   always_comb begin
      op5      = OP_ADD;
      mc       = 1'b0;
      ill      = 1'b0;
      shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

      case (aluop)
         ALUOP_MEM: op5 = OP_ADD;
         ALUOP_BRANCH: begin
            case (funct3[2:1])
               2'b00:   op5 = OP_SUB;
               2'b10:   op5 = OP_SLT;
               2'b11:   op5 = OP_SLTU;
               default: ill = 1'b1;
            endcase
         end
         ALUOP_ARITH: begin
            if (is_imm) begin
               // Only the shift immediates carry meaning in funct7.
               if (!shift_f3 || (funct7 == FUNCT7_BASE)) begin
                  op5 = base_op(funct3);
               end else if ((funct3 == 3'b101) && (funct7 == FUNCT7_ALT)) begin
                  op5 = OP_SRA;
               end else begin
                  ill = 1'b1;
               end
            end else begin
               case (funct7)
                  FUNCT7_BASE: op5 = base_op(funct3);
                  FUNCT7_ALT: begin
                     if (funct3 == 3'b000)      op5 = OP_SUB;
                     else if (funct3 == 3'b101) op5 = OP_SRA;
                     else                       ill = 1'b1;
                  end
                  FUNCT7_MULDIV: begin
                     if (EN_M) begin
                        op5 = {2'b10, funct3};
                        mc  = 1'b1;
                     end else begin
                        ill = 1'b1;
                     end
                  end
                  default: ill = 1'b1;
               endcase
            end
         end
         default: op5 = OP_PASSB;
      endcase

      // Illegal encodings still flow to EX as a harmless ADD for the trap path.
      if (ill) begin
         op5 = OP_ADD;
         mc  = 1'b0;
      end
   end

   assign operation  = OP_W'(op5);
   assign multicycle = mc;
   assign illegal    = ill;

endmodule

// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq
// Registered, handshaked ALU control between ID and EX. Decodes each accepted
// request (latency 1), holds the result until EX takes it, and tracks EX
// occupancy for multi-cycle MUL/DIV ops so that decode stalls while EX is busy.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of alu_ctrl_seq_if (handshakes, fields, decoded op, busy)
// -----------------------------------------------------------------------------
module alu_ctrl_seq
   import alu_ctrl_seq_pkg::*;
#(
   parameter int OP_W    = 5,
   parameter bit EN_M    = 1'b1,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_ctrl_seq_if.slave bus
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

   logic [OP_W-1:0]  dec_op;
   logic             dec_mc;
   logic             dec_ill;

   logic [OP_W-1:0]  op_p1;
   logic             mc_p1;
   logic             ill_p1;
   logic             vld_p1;
   logic [CNT_W-1:0] cnt;

   logic             busy;
   logic             in_rdy;
   logic             accept;
   logic             out_hs;

   alu_ctrl_seq_dec #(
      .OP_W (OP_W),
      .EN_M (EN_M)
   ) u_dec (
      .aluop      (bus.aluop),
      .funct3     (bus.funct3),
      .funct7     (bus.funct7),
      .is_imm     (bus.is_imm),
      .operation  (dec_op),
      .multicycle (dec_mc),
      .illegal    (dec_ill)
   );

   assign busy   = (cnt != '0);
   assign in_rdy = !bus.flush && !busy && (!vld_p1 || bus.out_ready);
   assign accept = bus.in_valid && in_rdy;
   assign out_hs = vld_p1 && bus.out_ready;

   // p0 -> p1: decoded op register, held until EX handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         op_p1  <= '0;
         mc_p1  <= 1'b0;
         ill_p1 <= 1'b0;
      end else if (bus.flush) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
         op_p1  <= dec_op;
         mc_p1  <= dec_mc;
         ill_p1 <= dec_ill;
      end else if (out_hs) begin
         vld_p1 <= 1'b0;
      end
   end

   // EX occupancy: loaded when a multi-cycle op leaves, counts down to idle.
   // A fresh load wins over the countdown so back-to-back M ops re-arm it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (bus.flush) begin
         cnt <= '0;
      end else if (out_hs && mc_p1) begin
         cnt <= is_div(op_p1[4:0]) ? DIV_LOAD : MUL_LOAD;
      end else if (busy) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign bus.in_ready   = in_rdy;
   assign bus.out_valid  = vld_p1;
   assign bus.operation  = op_p1;
   assign bus.multicycle = mc_p1;
   assign bus.illegal    = ill_p1;
   assign bus.busy       = busy;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_seq
// Bench for alu_ctrl_seq: a decode vector table, hand-written multi-cycle
// sequences (DIV occupancy, output hold, flush, async reset, EN_M=0) and a
// randomized run compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_seq;

   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 32;

   localparam logic [4:0] L_AND   = 5'd0;
   localparam logic [4:0] L_OR    = 5'd1;
   localparam logic [4:0] L_ADD   = 5'd2;
   localparam logic [4:0] L_XOR   = 5'd3;
   localparam logic [4:0] L_SLL   = 5'd4;
   localparam logic [4:0] L_SRL   = 5'd5;
   localparam logic [4:0] L_SUB   = 5'd6;
   localparam logic [4:0] L_SRA   = 5'd7;
   localparam logic [4:0] L_SLT   = 5'd8;
   localparam logic [4:0] L_SLTU  = 5'd9;
   localparam logic [4:0] L_PASSB = 5'd10;

   localparam logic [4:0] BASE_TBL [8] = '{L_ADD, L_SLL, L_SLT, L_SLTU,
                                           L_XOR, L_SRL, L_OR, L_AND};

   typedef struct packed {
      logic [1:0] aluop;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       imm;
      logic [4:0] op;
      logic       mc;
      logic       ill;
   } vec_t;

   typedef struct packed {
      logic [4:0] op;
      logic       mc;
      logic       ill;
      logic [7:0] lat;
   } ref_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_ctrl_seq_if #(.OP_W(5)) bus_a ();
   alu_ctrl_seq_if #(.OP_W(5)) bus_b ();

   alu_ctrl_seq #(.OP_W(5), .EN_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   alu_ctrl_seq #(.OP_W(5), .EN_M(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      bus_a.flush = 1'b0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
      bus_a.aluop = 2'd0; bus_a.funct3 = 3'd0; bus_a.funct7 = 7'd0; bus_a.is_imm = 1'b0;
   endtask

   task automatic drive_a(input logic [1:0] a, input logic [2:0] f3,
                          input logic [6:0] f7, input logic imm);
      bus_a.aluop = a; bus_a.funct3 = f3; bus_a.funct7 = f7; bus_a.is_imm = imm;
      bus_a.in_valid = 1'b1;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus_a.in_ready) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   // Reference decode straight from the instruction-set rules.
   function automatic ref_t ref_decode(input logic [1:0] a, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic imm, input bit en_m);
      ref_t r;
      bit   shift;
      r = '{op: L_ADD, mc: 1'b0, ill: 1'b0, lat: 8'd0};
      shift = (f3 == 3'd1) || (f3 == 3'd5);
      if (a == 2'd0) r.op = L_ADD;
      else if (a == 2'd3) r.op = L_PASSB;
      else if (a == 2'd1) begin
         if (f3 == 3'd2 || f3 == 3'd3) r.ill = 1'b1;
         else r.op = (f3 < 3'd2) ? L_SUB : ((f3 < 3'd6) ? L_SLT : L_SLTU);
      end else if (imm) begin
         if (!shift || f7 == 7'h00) r.op = BASE_TBL[f3];
         else if (f3 == 3'd5 && f7 == 7'h20) r.op = L_SRA;
         else r.ill = 1'b1;
      end else begin
         if (f7 == 7'h00) r.op = BASE_TBL[f3];
         else if (f7 == 7'h20 && f3 == 3'd0) r.op = L_SUB;
         else if (f7 == 7'h20 && f3 == 3'd5) r.op = L_SRA;
         else if (f7 == 7'h01 && en_m) begin
            r.op  = 5'd16 + 5'(f3);
            r.mc  = 1'b1;
            r.lat = (f3 < 3'd4) ? 8'(MUL_LAT) : 8'(DIV_LAT);
         end else r.ill = 1'b1;
      end
      if (r.ill) r.op = L_ADD;
      return r;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      bit   ok;
      int   n_busy;
      bit   m_vld;
      logic [4:0] m_op;
      logic m_mc, m_ill;
      int   m_lat, m_busy;
      bit   exp_rdy, hs, acc;
      ref_t d;

      vecs.push_back('{2'd2, 3'd0, 7'h20, 1'b0, L_SUB,   1'b0, 1'b0});
      vecs.push_back('{2'd0, 3'd5, 7'h55, 1'b0, L_ADD,   1'b0, 1'b0});
      vecs.push_back('{2'd3, 3'd3, 7'h7f, 1'b1, L_PASSB, 1'b0, 1'b0});
      vecs.push_back('{2'd1, 3'd0, 7'h00, 1'b0, L_SUB,   1'b0, 1'b0});
      vecs.push_back('{2'd1, 3'd5, 7'h00, 1'b0, L_SLT,   1'b0, 1'b0});
      vecs.push_back('{2'd1, 3'd7, 7'h00, 1'b0, L_SLTU,  1'b0, 1'b0});
      vecs.push_back('{2'd1, 3'd2, 7'h00, 1'b0, L_ADD,   1'b0, 1'b1});
      vecs.push_back('{2'd2, 3'd7, 7'h00, 1'b0, L_AND,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd6, 7'h00, 1'b0, L_OR,    1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd1, 7'h00, 1'b0, L_SLL,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd4, 7'h00, 1'b0, L_XOR,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd5, 7'h00, 1'b0, L_SRL,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd2, 7'h00, 1'b0, L_SLT,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd5, 7'h20, 1'b0, L_SRA,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd3, 7'h20, 1'b0, L_ADD,   1'b0, 1'b1});
      vecs.push_back('{2'd2, 3'd5, 7'h20, 1'b1, L_SRA,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd5, 7'h10, 1'b1, L_ADD,   1'b0, 1'b1});
      vecs.push_back('{2'd2, 3'd0, 7'h7f, 1'b1, L_ADD,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd1, 7'h20, 1'b1, L_ADD,   1'b0, 1'b1});
      vecs.push_back('{2'd2, 3'd1, 7'h00, 1'b1, L_SLL,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd0, 7'h01, 1'b1, L_ADD,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 3'd0, 7'h01, 1'b0, 5'd16,   1'b1, 1'b0});
      vecs.push_back('{2'd2, 3'd3, 7'h01, 1'b0, 5'd19,   1'b1, 1'b0});
      vecs.push_back('{2'd2, 3'd6, 7'h01, 1'b0, 5'd22,   1'b1, 1'b0});
      vecs.push_back('{2'd2, 3'd0, 7'h40, 1'b0, L_ADD,   1'b0, 1'b1});

      idle_a();
      bus_b.flush = 1'b0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
      bus_b.aluop = 2'd0; bus_b.funct3 = 3'd0; bus_b.funct7 = 7'd0; bus_b.is_imm = 1'b0;

      // Reset state
      #12;
      chk("rst a out_valid", bus_a.out_valid, 0);
      chk("rst a operation", bus_a.operation, 0);
      chk("rst a multicycle", bus_a.multicycle, 0);
      chk("rst a illegal", bus_a.illegal, 0);
      chk("rst a busy", bus_a.busy, 0);
      chk("rst b out_valid", bus_b.out_valid, 0);
      chk("rst b busy", bus_b.busy, 0);
      rst_n = 1'b1;
      tick();

      // Decode table, one request at a time with out_ready=1
      foreach (vecs[i]) begin
         wait_ready(ok);
         chk($sformatf("vec%0d wait_ready", i), ok, 1);
         drive_a(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].imm);
         tick();
         bus_a.in_valid = 1'b0;
         chk($sformatf("vec%0d out_valid", i), bus_a.out_valid, 1);
         chk($sformatf("vec%0d operation", i), bus_a.operation, vecs[i].op);
         chk($sformatf("vec%0d multicycle", i), bus_a.multicycle, vecs[i].mc);
         chk($sformatf("vec%0d illegal", i), bus_a.illegal, vecs[i].ill);
      end

      // DIV occupancy: busy for DIV_LAT-1 cycles after the handshake
      wait_ready(ok);
      chk("div wait_ready", ok, 1);
      drive_a(2'd2, 3'd4, 7'h01, 1'b0);
      tick();
      bus_a.in_valid = 1'b0;
      chk("div operation", bus_a.operation, 5'b10100);
      chk("div multicycle", bus_a.multicycle, 1);
      tick();
      n_busy = 0;
      for (int i = 0; i < 100; i++) begin
         if (!bus_a.busy) break;
         n_busy++;
         chk("div in_ready low", bus_a.in_ready, 0);
         tick();
      end
      chk("div busy cycles", n_busy, DIV_LAT - 1);

      // Output hold while out_ready=0
      bus_a.out_ready = 1'b0;
      wait_ready(ok);
      chk("hold wait_ready", ok, 1);
      drive_a(2'd2, 3'd7, 7'h00, 1'b0);
      tick();
      drive_a(2'd2, 3'd4, 7'h00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("hold operation", bus_a.operation, L_AND);
         chk("hold out_valid", bus_a.out_valid, 1);
         chk("hold in_ready", bus_a.in_ready, 0);
         tick();
      end
      bus_a.out_ready = 1'b1;
      #1;
      chk("hold release in_ready", bus_a.in_ready, 1);
      tick();
      bus_a.in_valid = 1'b0;
      chk("hold next operation", bus_a.operation, L_XOR);
      chk("hold next out_valid", bus_a.out_valid, 1);
      tick();

      // Flush squashes a held output
      bus_a.out_ready = 1'b0;
      drive_a(2'd2, 3'd6, 7'h00, 1'b0);
      tick();
      bus_a.in_valid = 1'b0;
      chk("flush hold pre valid", bus_a.out_valid, 1);
      bus_a.flush = 1'b1;
      tick();
      bus_a.flush = 1'b0;
      chk("flush hold valid", bus_a.out_valid, 0);
      bus_a.out_ready = 1'b1;

      // Flush during busy at cnt=10, with a competing request
      wait_ready(ok);
      chk("flush busy wait_ready", ok, 1);
      drive_a(2'd2, 3'd5, 7'h01, 1'b0);
      tick();
      bus_a.in_valid = 1'b0;
      tick();
      repeat (DIV_LAT - 11) tick();
      drive_a(2'd0, 3'd0, 7'h00, 1'b0);
      bus_a.flush = 1'b1;
      #1;
      chk("flush busy pre", bus_a.busy, 1);
      chk("flush in_ready", bus_a.in_ready, 0);
      tick();
      bus_a.flush = 1'b0;
      bus_a.in_valid = 1'b0;
      chk("flush busy cleared", bus_a.busy, 0);
      chk("flush no accept", bus_a.out_valid, 0);

      // Async reset mid-operation drops a pending DIV
      bus_a.out_ready = 1'b0;
      drive_a(2'd2, 3'd4, 7'h01, 1'b0);
      tick();
      bus_a.in_valid = 1'b0;
      chk("areset pre valid", bus_a.out_valid, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("areset out_valid", bus_a.out_valid, 0);
      chk("areset multicycle", bus_a.multicycle, 0);
      chk("areset operation", bus_a.operation, 0);
      #2 rst_n = 1'b1;
      bus_a.out_ready = 1'b1;
      tick();
      tick();
      chk("areset no busy", bus_a.busy, 0);
      chk("areset no valid", bus_a.out_valid, 0);

      // EN_M=0: mul-div funct7 is illegal and never occupies EX
      bus_b.aluop = 2'd2; bus_b.funct3 = 3'd0; bus_b.funct7 = 7'h01; bus_b.in_valid = 1'b1;
      tick();
      bus_b.funct3 = 3'd4;
      chk("nom illegal", bus_b.illegal, 1);
      chk("nom multicycle", bus_b.multicycle, 0);
      chk("nom operation", bus_b.operation, L_ADD);
      chk("nom out_valid", bus_b.out_valid, 1);
      n_busy = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus_b.busy) n_busy++;
         tick();
      end
      bus_b.in_valid = 1'b0;
      chk("nom busy count", n_busy, 0);

      // Randomized run against the reference model
      idle_a();
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      m_vld = 1'b0; m_op = '0; m_mc = 1'b0; m_ill = 1'b0; m_lat = 0; m_busy = 0;
      for (int c = 0; c < 1500; c++) begin
         bus_a.in_valid  = ($urandom_range(0, 9) < 6);
         bus_a.out_ready = ($urandom_range(0, 3) != 0);
         bus_a.flush     = ($urandom_range(0, 49) == 0);
         bus_a.aluop     = 2'($urandom_range(0, 3));
         bus_a.funct3    = 3'($urandom_range(0, 7));
         bus_a.is_imm    = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       bus_a.funct7 = 7'h00;
            1:       bus_a.funct7 = 7'h20;
            2:       bus_a.funct7 = 7'h01;
            default: bus_a.funct7 = 7'($urandom);
         endcase
         #1;
         exp_rdy = !bus_a.flush && (m_busy == 0) && (!m_vld || bus_a.out_ready);
         chk("rnd in_ready", bus_a.in_ready, exp_rdy);
         chk("rnd busy", bus_a.busy, (m_busy != 0));
         chk("rnd out_valid", bus_a.out_valid, m_vld);
         if (m_vld) begin
            chk("rnd operation", bus_a.operation, m_op);
            chk("rnd multicycle", bus_a.multicycle, m_mc);
            chk("rnd illegal", bus_a.illegal, m_ill);
         end
         d = ref_decode(bus_a.aluop, bus_a.funct3, bus_a.funct7, bus_a.is_imm, 1'b1);
         if (bus_a.flush) begin
            m_vld  = 1'b0;
            m_busy = 0;
         end else begin
            hs  = m_vld && bus_a.out_ready;
            acc = bus_a.in_valid && exp_rdy;
            if (hs && m_mc) m_busy = m_lat - 1;
            else if (m_busy > 0) m_busy--;
            if (acc) begin
               m_vld = 1'b1; m_op = d.op; m_mc = d.mc; m_ill = d.ill; m_lat = int'(d.lat);
            end else if (hs) begin
               m_vld = 1'b0;
            end
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
